// File: rtl/bus_arbiter_if.sv
// Shared memory-bus bundle between the two requesters, the arbiter and the decoder.
interface bus_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 8
);
  logic [1:0]    req;
  logic [1:0]    lock;
  logic [AW-1:0] m0_addr;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m0_wdata;
  logic [DW-1:0] m1_wdata;
  logic [1:0]    we;
  logic [1:0]    gnt;
  logic [1:0]    ack;
  logic [DW-1:0] rdata;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_data;
  logic          o_wren;
  logic [DW-1:0] i_data;

  // Requesters and decoder side.
  modport master (
    output req, lock, m0_addr, m1_addr, m0_wdata, m1_wdata, we, i_data,
    input  gnt, ack, rdata, o_addr, o_data, o_wren
  );

  // Arbiter side.
  modport slave (
    input  req, lock, m0_addr, m1_addr, m0_wdata, m1_wdata, we, i_data,
    output gnt, ack, rdata, o_addr, o_data, o_wren
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin two-master arbiter with bounded locked bursts; each transfer is a
// fixed ADDR/DATA pair matching one-cycle registered-read block RAMs.
module bus_arbiter #(
  parameter int AW        = 16,
  parameter int DW        = 8,
  parameter int MAX_BURST = 16
) (
  input  logic        clock,
  input  logic        reset,
  bus_arbiter_if.slave bus
);
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] BMAX = BW'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t        state;
  logic          owner;
  logic          last;
  logic [BW-1:0] burst;

  logic [1:0]    gnt_q;
  logic [1:0]    ack_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;
  logic          wren_q;

  logic          tie_pref;
  logic          win;
  logic          keep;
  logic          sel;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          sel_we;

  function automatic logic [1:0] onehot(input logic b);
    return b ? 2'b10 : 2'b01;
  endfunction

  // Outputs are registered: they are loaded on entry to ADDR from the selected
  // requester, which is equivalent because its inputs are stable while req is high.
  always_comb begin
    tie_pref  = (state == DATA) ? ~owner : ~last;
    win       = 1'b0;
    keep      = 1'b0;
    sel       = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    case (bus.req)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = tie_pref;
      default: win = 1'b0;
    endcase
    if (state == DATA)
      keep = bus.lock[owner] && bus.req[owner] && ((burst < BMAX) || !bus.req[~owner]);
    sel       = keep ? owner : win;
    sel_addr  = sel ? bus.m1_addr  : bus.m0_addr;
    sel_wdata = sel ? bus.m1_wdata : bus.m0_wdata;
    sel_we    = bus.we[sel];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      owner  <= 1'b0;
      last   <= 1'b1;
      burst  <= '0;
      gnt_q  <= '0;
      ack_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
      wren_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req) begin
            owner  <= sel;
            gnt_q  <= onehot(sel);
            addr_q <= sel_addr;
            data_q <= sel_wdata;
            wren_q <= sel_we;
            state  <= ADDR;
          end
        end
        ADDR: begin
          wren_q <= 1'b0;
          ack_q  <= onehot(owner);
          state  <= DATA;
        end
        DATA: begin
          last  <= owner;
          ack_q <= '0;
          if (keep || (|bus.req)) begin
            burst  <= keep ? ((burst == BMAX) ? burst : burst + 1'b1) : '0;
            owner  <= sel;
            gnt_q  <= onehot(sel);
            addr_q <= sel_addr;
            data_q <= sel_wdata;
            wren_q <= sel_we;
            state  <= ADDR;
          end else begin
            burst  <= '0;
            gnt_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
            wren_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.ack    = ack_q;
  assign bus.o_addr = addr_q;
  assign bus.o_data = data_q;
  assign bus.o_wren = wren_q;
  assign bus.rdata  = bus.i_data;
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-requester arbiter sharing the single 8-bit memory bus (program RAM, font RAM, video RAM, memory-mapped ports) between the CPU and a second bus master such as a UART program loader or DMA engine. It does round-robin arbitration with optional locked bursts. Each transfer is a fixed two-cycle ADDR/DATA sequence, matched to the one-cycle read latency of the synchronous block RAMs. It sits between the masters and the existing address decoder, which sees one `o_addr/o_data/o_wren/i_data` bus.

## Interface
- `AW` — 16 — address width.
- `DW` — 8 — data width.
- `MAX_BURST` — 16 — maximum consecutive transfers one owner may take under lock while the other requester waits; must be ≥1.

- `clock`  in  1  — single system clock; all logic on rising edge.
- `reset`  in  1  — synchronous, active-high.
- `req`  in  2  — per-requester transfer request; held until matching `ack`.
- `lock`  in  2  — per-requester burst hold; sampled at end of DATA.
- `m0_addr`, `m1_addr`  in  AW  — requester addresses; stable while `req` is high.
- `m0_wdata`, `m1_wdata`  in  DW  — requester write data.
- `we`  in  2  — per-requester write (1) / read (0).
- `gnt`  out  2  — one-hot owner, high during ADDR and DATA of its transfer.
- `ack`  out  2  — one-cycle pulse in DATA for the owner.
- `rdata`  out  DW  — `i_data` passed through; valid when `ack` is high.
- `o_addr`  out  AW  — bus address.
- `o_data`  out  DW  — bus write data.
- `o_wren`  out  1  — bus write strobe.
- `i_data`  in  DW  — bus read data from the decoder.

## Operation
- States: IDLE, ADDR, DATA.
- Registers:
  - `state`
  - `owner` (1 bit)
  - `last` (1 bit): the previous owner
  - `burst` (counter, width ≥ clog2(MAX_BURST))
- **IDLE**
  - Bus outputs are 0; `gnt` = `ack` = 0.
  - If any `req` is set, pick the winner and go to ADDR.
- **Winner selection** (same rule in IDLE and at the end of DATA)
  - If only one requester is active, it wins.
  - If both are active, the one that is not `last` wins.
- **ADDR**
  - `o_addr` = owner's address.
  - `o_data` = owner's wdata.
  - `o_wren` = owner's `we`, for exactly this one cycle.
  - `gnt[owner]` = 1.
  - Always go to DATA.
- **DATA**
  - `o_addr` and `o_data` are held; `o_wren` = 0.
  - `gnt[owner]` = 1, `ack[owner]` = 1, `rdata` = `i_data`.
  - `ack` is also pulsed for writes.
  - At the end of DATA, set `last` ← `owner`, then take the first matching case below:
  - **Keep burst:** if `lock[owner]` & `req[owner]`, and either `burst < MAX_BURST-1` or the other requester is idle:
    - `burst` ← `burst+1`, saturating at MAX_BURST-1.
    - Stay on the same owner and go to ADDR.
  - **Re-arbitrate:** otherwise, if any `req` is set:
    - `burst` ← 0.
    - Select a winner and go to ADDR directly, with no IDLE bubble.
  - **Go idle:** otherwise:
    - `burst` ← 0.
    - Go to IDLE.
- A requester dropping `req` during ADDR does not abort the transfer; DATA and `ack` still occur.
- Requests are evaluated only in IDLE and at the end of DATA; `req` changes at other times are ignored.
- `lock` from the non-owner is ignored.
- Outputs are combinational from `state`/`owner` and the owner's inputs; no output depends combinationally on `req`.

## Timing
- **Reset values:**
  - state = IDLE, owner = 0, last = 1 (so requester 0 wins the first tie), burst = 0.
  - `gnt` = `ack` = 0, `o_wren` = 0, `o_addr` = 0, `o_data` = 0, `rdata` = `i_data` (don't-care).
- **Reset mid-transfer:**
  - The state returns to IDLE on the edge where `reset` is sampled high.
  - No `ack` is issued and `o_wren` is low from the next cycle on.
- **Latency:**
  - A `req` sampled in IDLE at edge N gives ADDR in cycle N+1 and DATA/`ack` in cycle N+2.
- **Throughput:**
  - One transfer every 2 cycles while requests are continuous, including when ownership switches.
- **Write strobe:**
  - `o_wren` is high for exactly 1 cycle per write and never in IDLE or DATA.
- **Read data:**
  - `i_data` must reflect the address presented in ADDR, i.e. a one-cycle registered-read RAM.
- **Starvation bound:**
  - A waiting requester is granted within 2·MAX_BURST+2 cycles.

## Test plan
- **Single read:** `req`=01, m0_addr=16'h0010, RAM[0x10]=8'hA5.
  - ADDR in cycle 1 after the request, `ack[0]` in cycle 2 with `rdata`=A5.
  - `o_wren` stays 0 throughout; return to IDLE.
- **Single write:** requester 1 writes 8'h3C to 16'hF005.
  - `o_wren` high for exactly one cycle, with `o_addr`=F005 and `o_data`=3C.
  - `ack[1]` in the next cycle.
- **Simultaneous requests after reset:** both `req` rise together, no lock.
  - Grant order 0,1,0,1…, one `ack` every 2 cycles, no IDLE cycles in between.
- **Locked burst:** MAX_BURST=4, requester 0 holds `lock` and `req`, requester 1 requests continuously.
  - Exactly 4 `ack[0]`, then 1 `ack[1]`, then 4 `ack[0]` again.
- **Lock with idle competitor:** requester 0 locked for 20 transfers, requester 1 idle.
  - All 20 transfers are granted back-to-back to requester 0 despite MAX_BURST.
- **Reset during ADDR of a write:**
  - `o_wren` is low in the following cycle, no `ack` is issued, and `gnt`=00.
  - After reset release, a pending `req` is served normally.
